// File: rtl/generic_table_store_pkg.sv
// Shared types for generic_table_store: FSM state, grant source and the parity helper.
// Parity words are only used when TABLE_STORE_PARITY_EN is defined.
package generic_table_store_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    NONE,
    LOOKUP,
    REG_WR,
    REG_RD,
    FORCED
  } grant_t;

  // Even parity over up to 64 data bits; callers zero-extend narrower words.
  function automatic logic parity_of(input logic [63:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/generic_table_store_mem.sv
// Single-port table array with a synchronous read register; one access per clock.
// Contents are never reset.
module generic_table_store_mem #(
  parameter int WIDTH      = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/generic_table_store.sv
// Table storage arbiter: lookups first, register writes then reads, with a starvation guard.
// Define TABLE_STORE_PARITY_EN to store and check an even-parity bit per entry.
module generic_table_store
  import generic_table_store_pkg::*;
#(
  parameter int TABLE_ENTRY_WIDTH = 8,
  parameter int TABLE_ADDR_WIDTH  = 8,
  parameter int STARVE_LIMIT      = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         table_rd_req,
  output logic                         table_rd_ack,
  input  logic [TABLE_ADDR_WIDTH-1:0]  table_rd_addr,
  output logic [TABLE_ENTRY_WIDTH-1:0] table_rd_data,
  input  logic                         table_wr_req,
  output logic                         table_wr_ack,
  input  logic [TABLE_ADDR_WIDTH-1:0]  table_wr_addr,
  input  logic [TABLE_ENTRY_WIDTH-1:0] table_wr_data,
  input  logic                         lookup_req,
  output logic                         lookup_rdy,
  input  logic [TABLE_ADDR_WIDTH-1:0]  lookup_addr,
  output logic                         lookup_vld,
  output logic [TABLE_ENTRY_WIDTH-1:0] lookup_data,
  output logic                         table_parity_err,
  output state_t                       state_dbg
);

`ifdef TABLE_STORE_PARITY_EN
  localparam int MW = TABLE_ENTRY_WIDTH + 1;
`else
  localparam int MW = TABLE_ENTRY_WIDTH;
`endif

  state_t state, state_next;
  grant_t grant;
  logic   reg_pending, reg_grant, grant_wr, grant_rd;
  logic   force_q;
  logic [7:0] starve_cnt;
  logic   rd_ack_q, wr_ack_q, lookup_vld_q;
  logic [TABLE_ENTRY_WIDTH-1:0] rd_hold, lk_hold;
  logic                         mem_en, mem_we;
  logic [TABLE_ADDR_WIDTH-1:0]  mem_addr;
  logic [MW-1:0]                mem_wdata, mem_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (reg_grant) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Register requests are only eligible in IDLE; the ACK cycle is a lockout.
  always_comb begin
    reg_pending = (state == IDLE) && (table_wr_req || table_rd_req);
    grant       = NONE;
    if (reg_pending && force_q)                      grant = FORCED;
    else if (lookup_req && lookup_rdy)               grant = LOOKUP;
    else if ((state == IDLE) && table_wr_req)        grant = REG_WR;
    else if ((state == IDLE) && table_rd_req)        grant = REG_RD;
    reg_grant = (grant == FORCED) || (grant == REG_WR) || (grant == REG_RD);
    grant_wr  = (grant == REG_WR) || ((grant == FORCED) && table_wr_req);
    grant_rd  = (grant == REG_RD) || ((grant == FORCED) && !table_wr_req);
    mem_en    = (grant != NONE);
    mem_we    = grant_wr;
    mem_addr  = (grant == LOOKUP) ? lookup_addr :
                grant_wr          ? table_wr_addr : table_rd_addr;
  end

`ifdef TABLE_STORE_PARITY_EN
  assign mem_wdata = {parity_of(64'(table_wr_data)), table_wr_data};
  assign table_parity_err = (rd_ack_q || lookup_vld_q) &&
    (mem_rdata[MW-1] != parity_of(64'(mem_rdata[TABLE_ENTRY_WIDTH-1:0])));
`else
  assign mem_wdata        = table_wr_data;
  assign table_parity_err = 1'b0;
`endif

  generic_table_store_mem #(
    .WIDTH      (MW),
    .ADDR_WIDTH (TABLE_ADDR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ack_q     <= 1'b0;
      wr_ack_q     <= 1'b0;
      lookup_vld_q <= 1'b0;
      rd_hold      <= '0;
      lk_hold      <= '0;
      starve_cnt   <= '0;
      force_q      <= 1'b0;
    end else begin
      rd_ack_q     <= grant_rd;
      wr_ack_q     <= grant_wr;
      lookup_vld_q <= (grant == LOOKUP);
      if (rd_ack_q)     rd_hold <= mem_rdata[TABLE_ENTRY_WIDTH-1:0];
      if (lookup_vld_q) lk_hold <= mem_rdata[TABLE_ENTRY_WIDTH-1:0];
      if (reg_grant) begin
        starve_cnt <= '0;
        force_q    <= 1'b0;
      end else if (reg_pending) begin
        starve_cnt <= starve_cnt + 8'd1;
        force_q    <= (starve_cnt + 8'd1 == 8'(STARVE_LIMIT));
      end else begin
        force_q    <= 1'b0;
      end
    end
  end

  // The read register in the array is live during the ack/vld cycle; holds cover the rest.
  assign table_rd_ack  = rd_ack_q;
  assign table_wr_ack  = wr_ack_q;
  assign lookup_vld    = lookup_vld_q;
  assign lookup_rdy    = !force_q;
  assign table_rd_data = rd_ack_q ? mem_rdata[TABLE_ENTRY_WIDTH-1:0] : rd_hold;
  assign lookup_data   = lookup_vld_q ? mem_rdata[TABLE_ENTRY_WIDTH-1:0] : lk_hold;
  assign state_dbg     = state;

endmodule

// File: tb/tb_generic_table_store.sv
// Bench for generic_table_store: directed scenarios plus randomized register traffic
// against an array/queue reference model of the table.
module tb_generic_table_store;
  import generic_table_store_pkg::*;

  localparam int LIMIT = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       table_rd_req, table_wr_req, lookup_req;
  logic       table_rd_ack, table_wr_ack, lookup_rdy, lookup_vld, table_parity_err;
  logic [7:0] table_rd_addr, table_wr_addr, table_wr_data, lookup_addr;
  logic [7:0] table_rd_data, lookup_data;
  state_t     state_dbg;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] model_mem [256];
  logic [7:0] exp_q [$];
  bit         lk_expect;

  generic_table_store #(
    .TABLE_ENTRY_WIDTH (8),
    .TABLE_ADDR_WIDTH  (8),
    .STARVE_LIMIT      (LIMIT)
  ) u_dut (
    .clk              (clk),
    .reset            (reset),
    .table_rd_req     (table_rd_req),
    .table_rd_ack     (table_rd_ack),
    .table_rd_addr    (table_rd_addr),
    .table_rd_data    (table_rd_data),
    .table_wr_req     (table_wr_req),
    .table_wr_ack     (table_wr_ack),
    .table_wr_addr    (table_wr_addr),
    .table_wr_data    (table_wr_data),
    .lookup_req       (lookup_req),
    .lookup_rdy       (lookup_rdy),
    .lookup_addr      (lookup_addr),
    .lookup_vld       (lookup_vld),
    .lookup_data      (lookup_data),
    .table_parity_err (table_parity_err),
    .state_dbg        (state_dbg)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard bookkeeping for one comparison result.
  task automatic check(input string tag, input bit ok,
                       input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: present a lookup for the next edge and record what it must return.
  task automatic drive_lookup(input int pct, input int fix);
    lookup_req  = ($urandom_range(0, 99) < 32'(pct));
    lookup_addr = (fix >= 0) ? 8'(fix) : 8'($urandom_range(0, 255));
    lk_expect   = lookup_req && lookup_rdy;
    if (lk_expect) exp_q.push_back(model_mem[lookup_addr]);
  endtask

  // Advance one clock and check the lookup channel.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    check("lookup_vld", lookup_vld === lk_expect, lookup_vld, lk_expect);
    if (lookup_vld && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("lookup_data", lookup_data === e, lookup_data, e);
    end
    check("parity_err_idle", table_parity_err === 1'b0, table_parity_err, 1'b0);
  endtask

  // One register operation with background lookups; requester holds req through the ack edge.
  task automatic run_op(input bit wr, input logic [7:0] a, input logic [7:0] d,
                        input int pct, input int fix, output int lat, output int rdy_low);
    bit got;
    lat = 0; rdy_low = 0; got = 0;
    if (wr) begin
      table_wr_req = 1'b1; table_wr_addr = a; table_wr_data = d;
    end else begin
      table_rd_req = 1'b1; table_rd_addr = a;
    end
    while (!got && lat <= LIMIT + 1) begin
      if (!lookup_rdy) rdy_low++;
      drive_lookup(pct, fix);
      step();
      lat++;
      if (wr) check("stray_rd_ack", table_rd_ack === 1'b0, table_rd_ack, 1'b0);
      else    check("stray_wr_ack", table_wr_ack === 1'b0, table_wr_ack, 1'b0);
      got = wr ? table_wr_ack : table_rd_ack;
    end
    check("op_acked", got === 1'b1, got, 1'b1);
    check("lat_bound", lat <= LIMIT + 1, lat, LIMIT + 1);
    if (wr) model_mem[a] = d;
    else if (got) check("rd_data", table_rd_data === model_mem[a], table_rd_data, model_mem[a]);
    if (!lookup_rdy) rdy_low++;
    drive_lookup(pct, fix);
    step();
    check("lockout_wr_ack", table_wr_ack === 1'b0, table_wr_ack, 1'b0);
    check("lockout_rd_ack", table_rd_ack === 1'b0, table_rd_ack, 1'b0);
    if (!wr && got)
      check("rd_data_hold", table_rd_data === model_mem[a], table_rd_data, model_mem[a]);
    table_wr_req = 1'b0;
    table_rd_req = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check("rst_rd_ack", table_rd_ack === 1'b0, table_rd_ack, 1'b0);
    check("rst_wr_ack", table_wr_ack === 1'b0, table_wr_ack, 1'b0);
    check("rst_lookup_vld", lookup_vld === 1'b0, lookup_vld, 1'b0);
    check("rst_parity_err", table_parity_err === 1'b0, table_parity_err, 1'b0);
    check("rst_rd_data", table_rd_data === 8'h00, table_rd_data, 8'h00);
    check("rst_lookup_data", lookup_data === 8'h00, lookup_data, 8'h00);
    check("rst_lookup_rdy", lookup_rdy === 1'b1, lookup_rdy, 1'b1);
  endtask

  initial begin
    int lat, rl, wr_at, rd_at, wr_n, rd_n;
    logic [7:0] d;

    // Reset
    reset = 1'b1;
    table_rd_req = 1'b0; table_wr_req = 1'b0; lookup_req = 1'b0;
    table_rd_addr = '0; table_wr_addr = '0; table_wr_data = '0; lookup_addr = '0;
    lk_expect = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    drive_lookup(0, -1);
    step();

    // Uncontended write then read back
    run_op(1'b1, 8'h05, 8'hA5, 0, -1, lat, rl);
    check("wr_latency_1", lat === 1, lat, 1);
    run_op(1'b0, 8'h05, 8'h00, 0, -1, lat, rl);
    check("rd_latency_1", lat === 1, lat, 1);
    check("rd_a5", table_rd_data === 8'hA5, table_rd_data, 8'hA5);

    // Fill the whole table so every later read/lookup has a known value
    for (int i = 0; i < 256; i++) begin
      run_op(1'b1, 8'(i), 8'($urandom_range(0, 255)), 0, -1, lat, rl);
    end

    // Starvation: lookups every cycle on 0x05 while a write waits
    run_op(1'b1, 8'h40, 8'($urandom_range(0, 255)), 100, 5, lat, rl);
    check("starve_latency", lat === LIMIT + 1, lat, LIMIT + 1);
    check("starve_rdy_low_cycles", rl === 1, rl, 1);

    // Simultaneous read and write: write first, read two cycles later
    table_wr_req = 1'b1; table_wr_addr = 8'h20; d = 8'($urandom_range(0, 255)); table_wr_data = d;
    table_rd_req = 1'b1; table_rd_addr = 8'h21;
    wr_at = 0; rd_at = 0; wr_n = 0; rd_n = 0;
    for (int c = 1; c <= 6; c++) begin
      drive_lookup(0, -1);
      step();
      if (table_wr_ack) begin
        wr_n++;
        if (wr_at == 0) wr_at = c;
        model_mem[8'h20] = d;
      end
      if (table_rd_ack) begin
        rd_n++;
        if (rd_at == 0) rd_at = c;
        check("both_rd_data", table_rd_data === model_mem[8'h21], table_rd_data, model_mem[8'h21]);
      end
      if (wr_at != 0 && c == wr_at + 1) table_wr_req = 1'b0;
      if (rd_at != 0 && c == rd_at + 1) table_rd_req = 1'b0;
    end
    table_wr_req = 1'b0; table_rd_req = 1'b0;
    check("both_wr_at", wr_at === 1, wr_at, 1);
    check("both_rd_at", rd_at === 3, rd_at, 3);
    check("both_wr_count", wr_n === 1, wr_n, 1);
    check("both_rd_count", rd_n === 1, rd_n, 1);

`ifdef TABLE_STORE_PARITY_EN
    // Corrupt one stored bit at 0x10 and look it up
    d = 8'($urandom_range(0, 255));
    run_op(1'b1, 8'h10, d, 0, -1, lat, rl);
    u_dut.u_mem.mem[16] = u_dut.u_mem.mem[16] ^ 9'h001;
    lookup_req = 1'b1; lookup_addr = 8'h10; lk_expect = 1'b0;
    @(negedge clk);
    lookup_req = 1'b0;
    check("par_lookup_vld", lookup_vld === 1'b1, lookup_vld, 1'b1);
    check("par_err", table_parity_err === 1'b1, table_parity_err, 1'b1);
    check("par_data_unmodified", lookup_data === (d ^ 8'h01), lookup_data, d ^ 8'h01);
    drive_lookup(0, -1);
    step();
    run_op(1'b1, 8'h10, d, 0, -1, lat, rl);
`endif

    // Reset in the cycle after a write grant
    drive_lookup(0, -1);
    lk_expect = 1'b0;
    d = 8'($urandom_range(0, 255));
    table_wr_req = 1'b1; table_wr_addr = 8'h33; table_wr_data = d;
    @(posedge clk);
    #1;
    reset = 1'b1;
    table_wr_req = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    model_mem[8'h33] = d;
    drive_lookup(0, -1);
    step();
    check("post_reset_no_wr_ack", table_wr_ack === 1'b0, table_wr_ack, 1'b0);
    run_op(1'b0, 8'h33, 8'h00, 0, -1, lat, rl);
    run_op(1'b0, 8'h05, 8'h00, 0, -1, lat, rl);

    // Random register traffic under random lookup pressure
    for (int i = 0; i < 80; i++) begin
      run_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             int'($urandom_range(0, 100)), -1, lat, rl);
    end

    drive_lookup(0, -1);
    step();
    check("lookup_queue_drained", exp_q.size() === 0, exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
